// File: rtl/stage_wb.sv
// stage_wb: writeback stage directly downstream of the memory stage.
//   Owns the MEM/WB pipeline register and selects the writeback source
//   (ALU, load, PC+4, or zero for the reserved code). It formats load data
//   (byte/half/word, sign/zero extension) and flags misaligned loads. It also
//   counts retired instructions. Because the synchronous DMEM/I/O read data
//   moves on with the next MEM-stage address, the formatted load value is
//   latched on the first WB cycle. Stalled cycles then replay it from that copy.
// Ports:
//   i_clk, i_reset (async, active-low)
//   MEM-side: i_pc, i_alu_result, i_funct3, i_rd_addr, i_rd_wren, i_mem_read,
//             i_wb_sel, i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill
//   control : i_stall (hold MEM/WB), i_flush (bubble into WB, wins over stall)
//   read data: i_dmem_rdata, i_io_rdata (valid the cycle after the address)
//   outputs : o_rd_addr, o_rd_data, o_rd_wren, o_misaligned, o_insn_vld,
//             o_pc_debug, o_instret
module stage_wb #(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_alu_result,
  input  logic [2:0]           i_funct3,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_rd_wren,
  input  logic                 i_mem_read,
  input  logic [1:0]           i_wb_sel,
  input  logic                 i_ctrl_valid,
  input  logic                 i_ctrl_bubble,
  input  logic                 i_ctrl_kill,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [31:0]          i_dmem_rdata,
  input  logic [31:0]          i_io_rdata,
  output logic [4:0]           o_rd_addr,
  output logic [31:0]          o_rd_data,
  output logic                 o_rd_wren,
  output logic                 o_misaligned,
  output logic                 o_insn_vld,
  output logic [31:0]          o_pc_debug,
  output logic [INSTRET_W-1:0] o_instret
);

  // I/O window 0x1000_0000..0x1001_FFFF, identified by address[31:17].
  localparam logic [14:0] IO_PAGE = 15'h0800;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  logic                 valid_r;
  logic [31:0]          pc_r;
  logic [31:0]          addr_r;
  logic [2:0]           funct3_r;
  logic [4:0]           rd_addr_r;
  logic                 rd_wren_r;
  logic                 mem_read_r;
  logic [1:0]           wb_sel_r;
  logic                 first_r;
  logic [31:0]          hold_r;
  logic [INSTRET_W-1:0] instret_r;

  logic [31:0]          load_word_s;
  logic [31:0]          load_fmt_s;
  logic                 misaligned_s;
  logic                 insn_vld_s;
  logic [31:0]          rd_data_s;

  // Extract and extend the addressed byte/half/word of a load.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = w;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Half-words need addr[0]=0, words need addr[1:0]=0; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3)
      3'b001, 3'b101: m = a[0];
      3'b010:         m = (a != 2'b00);
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  assign load_word_s  = (addr_r[31:17] == IO_PAGE) ? i_io_rdata : i_dmem_rdata;
  assign load_fmt_s   = fmt_load(funct3_r, addr_r[1:0], load_word_s);
  assign misaligned_s = mem_read_r & is_misaligned(funct3_r, addr_r[1:0]);
  assign insn_vld_s   = valid_r & first_r & ~misaligned_s;

  // Writeback data mux; loads replay the held copy once the live data has moved on.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (wb_sel_r)
      WB_ALU:  rd_data_s = addr_r;
      WB_LOAD: begin
        if (first_r) begin
          rd_data_s = load_fmt_s;
        end else begin
          rd_data_s = hold_r;
        end
      end
      WB_PC4:  rd_data_s = pc_r + 32'd4;
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // MEM/WB pipeline register: flush > stall > capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_r    <= 1'b0;
      pc_r       <= 32'h0000_0000;
      addr_r     <= 32'h0000_0000;
      funct3_r   <= 3'b000;
      rd_addr_r  <= 5'd0;
      rd_wren_r  <= 1'b0;
      mem_read_r <= 1'b0;
      wb_sel_r   <= 2'd0;
      first_r    <= 1'b0;
    end else if (i_flush) begin
      valid_r    <= 1'b0;
      pc_r       <= 32'h0000_0000;
      addr_r     <= 32'h0000_0000;
      funct3_r   <= 3'b000;
      rd_addr_r  <= 5'd0;
      rd_wren_r  <= 1'b0;
      mem_read_r <= 1'b0;
      wb_sel_r   <= 2'd0;
      first_r    <= 1'b0;
    end else if (i_stall) begin
      first_r    <= 1'b0;
    end else begin
      valid_r    <= i_ctrl_valid & ~i_ctrl_bubble & ~i_ctrl_kill;
      pc_r       <= i_pc;
      addr_r     <= i_alu_result;
      funct3_r   <= i_funct3;
      rd_addr_r  <= i_rd_addr;
      rd_wren_r  <= i_rd_wren;
      mem_read_r <= i_mem_read;
      wb_sel_r   <= i_wb_sel;
      first_r    <= 1'b1;
    end
  end

  // Latch the formatted load value while the read data is still live.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hold_r <= 32'h0000_0000;
    end else if (first_r && (wb_sel_r == WB_LOAD)) begin
      hold_r <= load_fmt_s;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Retired-instruction counter, wraps naturally at its maximum.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      instret_r <= '0;
    end else if (insn_vld_s) begin
      instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign o_rd_addr    = rd_addr_r;
  assign o_rd_data    = rd_data_s;
  assign o_rd_wren    = valid_r & first_r & rd_wren_r & (rd_addr_r != 5'd0) & ~misaligned_s;
  assign o_misaligned = valid_r & first_r & misaligned_s;
  assign o_insn_vld   = insn_vld_s;
  assign o_pc_debug   = pc_r;
  assign o_instret    = instret_r;

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc, alu_result, dmem_rdata, io_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic        rd_wren, mem_read, ctrl_valid, ctrl_bubble, ctrl_kill, stall, flush;
  logic [1:0]  wb_sel;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_pc_debug, o_instret;
  logic        o_rd_wren, o_misaligned, o_insn_vld;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret;

  stage_wb #(.INSTRET_W(32)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_pc(pc), .i_alu_result(alu_result),
    .i_funct3(funct3), .i_rd_addr(rd_addr), .i_rd_wren(rd_wren),
    .i_mem_read(mem_read), .i_wb_sel(wb_sel), .i_ctrl_valid(ctrl_valid),
    .i_ctrl_bubble(ctrl_bubble), .i_ctrl_kill(ctrl_kill), .i_stall(stall),
    .i_flush(flush), .i_dmem_rdata(dmem_rdata), .i_io_rdata(io_rdata),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
    .o_misaligned(o_misaligned), .o_insn_vld(o_insn_vld),
    .o_pc_debug(o_pc_debug), .o_instret(o_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wren;
    logic        mread;
    logic [1:0]  sel;
    logic [31:0] dmem;
    logic [31:0] io;
    logic [31:0] exp_data;
    logic        exp_wren;
    logic        exp_mis;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] p, input logic [31:0] a, input logic [2:0] f,
                         input logic [4:0] r, input logic w, input logic m, input logic [1:0] s);
    pc = p; alu_result = a; funct3 = f; rd_addr = r; rd_wren = w; mem_read = m;
    wb_sel = s; ctrl_valid = 1'b1; ctrl_bubble = 1'b0; ctrl_kill = 1'b0;
  endtask

  task automatic idle_mem;
    pc = 32'h0; alu_result = 32'h0; funct3 = 3'b000; rd_addr = 5'd0; rd_wren = 1'b0;
    mem_read = 1'b0; wb_sel = 2'd0; ctrl_valid = 1'b0; ctrl_bubble = 1'b0; ctrl_kill = 1'b0;
  endtask

  initial begin
    //          name        pc            addr          f3      rd  wr mr sel  dmem          io            exp_data      ew mis vld
    vecs[0]  = '{"lw",      32'h0000_0040, 32'h0000_0010, 3'b010, 5'd5, 1'b1, 1'b1, 2'd1, 32'h8000_00F0, 32'h0, 32'h8000_00F0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{"lb",      32'h0000_0044, 32'h0000_0013, 3'b000, 5'd6, 1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"lbu",     32'h0000_0048, 32'h0000_0013, 3'b100, 5'd6, 1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h0, 32'h0000_0080, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{"lhu",     32'h0000_004C, 32'h0000_0012, 3'b101, 5'd7, 1'b1, 1'b1, 2'd1, 32'hBEEF_0000, 32'h0, 32'h0000_BEEF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{"lw_io",   32'h0000_0050, 32'h1001_0000, 3'b010, 5'd8, 1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF, 32'h0000_00A5, 32'h0000_00A5, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{"lw_mis",  32'h0000_0054, 32'h0000_0002, 3'b010, 5'd9, 1'b1, 1'b1, 2'd1, 32'h1111_2222, 32'h0, 32'h1111_2222, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"alu_x0",  32'h0000_0058, 32'h0000_0055, 3'b000, 5'd0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{"jal",     32'h0000_0100, 32'h0000_0000, 3'b000, 5'd1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0000_0104, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"lh",      32'h0000_005C, 32'h0000_0012, 3'b001, 5'd10, 1'b1, 1'b1, 2'd1, 32'h8001_0000, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"lb_pos",  32'h0000_0060, 32'h0000_0011, 3'b000, 5'd11, 1'b1, 1'b1, 2'd1, 32'h0000_7F00, 32'h0, 32'h0000_007F, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"sel_rsv", 32'h0000_0064, 32'h0000_1234, 3'b000, 5'd3, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{"lh_mis",  32'h0000_0068, 32'h0000_0013, 3'b001, 5'd12, 1'b1, 1'b1, 2'd1, 32'h8001_0000, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{"f3_bad",  32'h0000_006C, 32'h0000_0000, 3'b011, 5'd13, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{"pc_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 3'b000, 5'd14, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h0; io_rdata = 32'h0;
    idle_mem();
    exp_instret = 32'h0;
    #12;
    chk("rst_rd_data", o_rd_data, 32'h0);
    chk("rst_wren", {31'h0, o_rd_wren}, 32'h0);
    chk("rst_vld", {31'h0, o_insn_vld}, 32'h0);
    chk("rst_instret", o_instret, 32'h0);
    rst_n = 1'b1;

    // Table vectors: instruction spends one cycle in MEM, checked in WB next cycle.
    for (int i = 0; i < 14; i++) begin
      tick();
      set_mem(vecs[i].pc, vecs[i].addr, vecs[i].f3, vecs[i].rd, vecs[i].wren, vecs[i].mread, vecs[i].sel);
      tick();
      idle_mem();
      dmem_rdata = vecs[i].dmem;
      io_rdata = vecs[i].io;
      #3;
      chk({vecs[i].name, "_data"}, o_rd_data, vecs[i].exp_data);
      chk({vecs[i].name, "_wren"}, {31'h0, o_rd_wren}, {31'h0, vecs[i].exp_wren});
      chk({vecs[i].name, "_mis"}, {31'h0, o_misaligned}, {31'h0, vecs[i].exp_mis});
      chk({vecs[i].name, "_vld"}, {31'h0, o_insn_vld}, {31'h0, vecs[i].exp_vld});
      chk({vecs[i].name, "_rd"}, {27'h0, o_rd_addr}, {27'h0, vecs[i].rd});
      chk({vecs[i].name, "_pc"}, o_pc_debug, vecs[i].pc);
      if (vecs[i].exp_vld) exp_instret = exp_instret + 32'd1;
      tick();
      chk({vecs[i].name, "_instret"}, o_instret, exp_instret);
      chk({vecs[i].name, "_mis_gone"}, {31'h0, o_misaligned}, 32'h0);
    end

    // LW followed by a three-cycle stall while the read data moves on.
    set_mem(32'h0000_0200, 32'h0000_0020, 3'b010, 5'd7, 1'b1, 1'b1, 2'd1);
    tick();
    idle_mem();
    stall = 1'b1;
    dmem_rdata = 32'hCAFE_0001;
    #3;
    chk("stall_first_data", o_rd_data, 32'hCAFE_0001);
    chk("stall_first_wren", {31'h0, o_rd_wren}, 32'h1);
    exp_instret = exp_instret + 32'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      dmem_rdata = 32'h1234_5678;
      #3;
      chk("stall_hold_data", o_rd_data, 32'hCAFE_0001);
      chk("stall_hold_wren", {31'h0, o_rd_wren}, 32'h0);
      chk("stall_hold_vld", {31'h0, o_insn_vld}, 32'h0);
      chk("stall_instret", o_instret, exp_instret);
    end
    stall = 1'b0;
    tick();
    #3;
    chk("after_stall_wren", {31'h0, o_rd_wren}, 32'h0);
    chk("after_stall_instret", o_instret, exp_instret);

    // JAL captured together with flush: only a bubble reaches WB.
    set_mem(32'h0000_0100, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, 2'd2);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle_mem();
    #3;
    chk("flush_wren", {31'h0, o_rd_wren}, 32'h0);
    chk("flush_vld", {31'h0, o_insn_vld}, 32'h0);
    chk("flush_data", o_rd_data, 32'h0);
    tick();
    chk("flush_instret", o_instret, exp_instret);

    // Same JAL without flush.
    set_mem(32'h0000_0100, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, 2'd2);
    tick();
    idle_mem();
    #3;
    chk("jal2_data", o_rd_data, 32'h0000_0104);
    chk("jal2_wren", {31'h0, o_rd_wren}, 32'h1);
    exp_instret = exp_instret + 32'd1;
    tick();
    chk("jal2_instret", o_instret, exp_instret);

    // Reset asserted while an instruction is held by a stall.
    set_mem(32'h0000_0300, 32'h0000_0030, 3'b010, 5'd9, 1'b1, 1'b1, 2'd1);
    tick();
    idle_mem();
    stall = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", o_rd_data, 32'h0);
    chk("rst_mid_wren", {31'h0, o_rd_wren}, 32'h0);
    chk("rst_mid_vld", {31'h0, o_insn_vld}, 32'h0);
    chk("rst_mid_rd", {27'h0, o_rd_addr}, 32'h0);
    chk("rst_mid_pc", o_pc_debug, 32'h0);
    chk("rst_mid_instret", o_instret, 32'h0);
    #10;
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    #3;
    chk("post_rst_wren", {31'h0, o_rd_wren}, 32'h0);
    chk("post_rst_instret", o_instret, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Writeback stage directly downstream of the memory stage; owns the MEM/WB pipeline register.
- Selects the writeback source (ALU, DMEM, I/O or PC+4) and formats load data (byte/half/word, sign/zero extension).
- Drives the register-file write port and the WB forwarding value, flags misaligned loads, and counts retired instructions.
- Holds load data stable across pipeline stalls, because the synchronous DMEM/I/O read data moves on with the next MEM-stage address.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_pc  in  32  PC of the instruction in MEM.
- i_alu_result  in  32  ALU result / effective address from MEM.
- i_funct3  in  3  load width/sign from MEM.
- i_rd_addr  in  5  destination register.
- i_rd_wren  in  1  instruction writes rd.
- i_mem_read  in  1  instruction is a load.
- i_wb_sel  in  2  0=ALU, 1=load, 2=PC+4, 3=reserved (writes 0).
- i_ctrl_valid  in  1  MEM slot holds an instruction.
- i_ctrl_bubble  in  1  MEM slot is a bubble.
- i_ctrl_kill  in  1  MEM instruction was flushed.
- i_stall  in  1  hold the MEM/WB register.
- i_flush  in  1  insert a bubble into WB.
- i_dmem_rdata  in  32  synchronous DMEM read data; valid in the cycle after the address was in MEM.
- i_io_rdata  in  32  registered I/O read data; same timing as i_dmem_rdata.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data; also the WB forwarding value.
- o_rd_wren  out  1  register-file write enable.
- o_misaligned  out  1  one-cycle pulse on a misaligned load in WB.
- o_insn_vld  out  1  WB holds a committing instruction (first cycle only).
- o_pc_debug  out  32  PC of the instruction in WB.
- o_instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - all pipeline fields, the hold register and the counter clear to 0.
  - o_rd_wren=0, o_insn_vld=0, o_misaligned=0, o_rd_data=0, o_rd_addr=0, o_pc_debug=0, o_instret=0.
- MEM/WB register update at posedge, in priority order:
  - i_flush: load a bubble (valid=0, all fields 0).
  - else i_stall: hold all fields.
  - else capture all inputs. wb_valid = i_ctrl_valid & ~i_ctrl_bubble & ~i_ctrl_kill.
- first flag:
  - set on every capture; cleared on the first stalled cycle after a capture.
  - WB side effects happen only while first=1.
- Load source: I/O if the registered address[31:17]==15'h0800 (range 0x1000_0000–0x1001_FFFF); otherwise DMEM.
- Load formatting uses the registered funct3 and address[1:0]:
  - LB/LBU (000/100): selected byte lane, sign- or zero-extended.
  - LH/LHU (001/101): half-word at address[1].
  - LW (010): full word.
  - Other funct3 values: 0.
- Misaligned load:
  - Condition: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Response: o_misaligned=1 for the first cycle, o_rd_wren=0, no retire.
- Hold register:
  - When first=1 and wb_sel=1, the formatted load value is captured into hold at posedge.
  - While first=0, o_rd_data for loads comes from hold, not from the live read inputs.
- Writeback source: wb_sel=0 gives alu_result; wb_sel=2 gives pc+4 (32-bit wrap).
- o_rd_data is combinational from the registered fields.
- o_rd_wren = wb_valid & first & rd_wren & (rd_addr!=0) & ~misaligned.
- o_insn_vld = wb_valid & first & ~misaligned.
- o_instret increments by 1 on each posedge where o_insn_vld=1; wraps to 0 at the maximum value.
- Stall and flush in the same cycle: flush wins.
- Reset mid-stall: discards the held instruction with no writeback.

Test Plan:
- Reset, then LW at 0x0000_0010 with dmem returning 0x8000_00F0 and rd=5 → next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x8000_00F0, o_instret=1.
- LB at addr 0x13, dmem 0x8000_0000 → o_rd_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x12, dmem 0xBEEF_0000 → 0x0000_BEEF.
- LW at 0x1001_0000, io_rdata=0x0000_00A5, dmem=0xDEAD_BEEF → o_rd_data=0x0000_00A5.
- LW, then i_stall for 3 cycles while dmem_rdata changes to 0x1234_5678 → o_rd_data holds the original value, o_rd_wren=1 only in the first cycle, o_instret +1 only.
- LW at 0x0000_0002 → o_misaligned pulses one cycle, o_rd_wren=0, o_instret unchanged. Write to rd=0 → o_rd_wren=0, o_instret increments.
- JAL (wb_sel=2, pc=0x0000_0100) captured with i_flush=1 → no writeback. Same JAL without flush → o_rd_data=0x0000_0104. Assert i_reset=0 mid-stall → all outputs 0 immediately.
